// File: rtl/mc_pkg.sv
// Shared types and defaults for the multicycle divide/sqrt sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_pkg;

    typedef enum logic [1:0] {
        MC_DIV   = 2'b00,
        MC_REM   = 2'b01,
        MC_FDIV  = 2'b10,
        MC_FSQRT = 2'b11
    } mc_op_e;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'b00,
        MC_ISSUE = 2'b01,
        MC_WAIT  = 2'b10,
        MC_WB    = 2'b11
    } mc_state_e;

    localparam int MC_DEF_TIMEOUT = 64;
    localparam int MC_DEF_CNT_W   = 7;

    // Everything captured from EX at accept; held until the writeback handshake.
    typedef struct packed {
        mc_op_e     op;
        logic [4:0] rd;
        logic       fp;
        logic       special;
    } mc_rec_t;

    // FP ops live in the upper half of the opcode space.
    function automatic logic mc_op_is_fp(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/mc_watchdog_cnt.sv
// Watchdog: clear/enable counter that saturates at TIMEOUT and flags the cycle it gets there.
// Latency: hit_o is combinational in the enabled cycle whose increment reaches TIMEOUT.
// Backpressure: none; counts whenever enabled.
module mc_watchdog_cnt
    import mc_pkg::*;
#(
    parameter int TIMEOUT = MC_DEF_TIMEOUT,
    parameter int CNT_W   = MC_DEF_CNT_W   // 2**CNT_W must exceed TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over enable; saturate at LIMIT so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the enabled cycle whose increment lands on TIMEOUT (or if already there).
    assign hit_o = en_i && !clr_i && (cnt_q >= LAST);

endmodule

// File: rtl/multicycle_unit_ctrl.sv
// Sequences one shared iterative divide/sqrt unit and hands its result to writeback.
// Latency: wb_valid 1 cycle after unit_done; div-by-zero special 1 cycle after accept.
// Backpressure: holds WB (and stall_ex) while wb_ready=0; only accepts new work in IDLE.
module multicycle_unit_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT = MC_DEF_TIMEOUT,
    parameter int CNT_W   = MC_DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_req,
    input  logic [1:0] ex_op,
    input  logic [4:0] ex_rd,
    input  logic       ex_div_zero,
    input  logic       ex_kill,
    output logic       unit_start,
    output logic [1:0] unit_op,
    input  logic       unit_done,
    output logic       wb_valid,
    input  logic       wb_ready,
    output logic [4:0] wb_rd,
    output logic       wb_fp,
    output logic       wb_special,
    output logic       stall_ex,
    output logic       mc_busy,
    output logic       err_timeout
);

    mc_state_e state_q, state_d;
    mc_rec_t   rec_q, rec_d;
    logic      err_q, err_d;
    logic      accept;
    logic      acc_special;
    logic      wd_hit;

    // An op is taken only from IDLE and only if EX is not flushing it.
    assign accept      = (state_q == MC_IDLE) && ex_req && !ex_kill;
    // Div-by-zero on an integer op bypasses the unit; FP ops ignore the flag.
    assign acc_special = ex_div_zero && !mc_op_is_fp(ex_op);

    mc_watchdog_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q == MC_ISSUE),
        .en_i  (state_q == MC_WAIT),
        .hit_o (wd_hit)
    );

    // Next-state, op-record capture and sticky timeout flag.
    always_comb begin
        state_d = state_q;
        rec_d   = rec_q;
        err_d   = err_q;
        case (state_q)
            MC_IDLE: begin
                if (accept) begin
                    rec_d.op      = mc_op_e'(ex_op);
                    rec_d.rd      = ex_rd;
                    rec_d.fp      = mc_op_is_fp(ex_op);
                    rec_d.special = acc_special;
                    state_d       = acc_special ? MC_WB : MC_ISSUE;
                end
            end
            MC_ISSUE: begin
                state_d = MC_WAIT;
            end
            MC_WAIT: begin
                // A completion in the last allowed cycle beats the watchdog.
                if (unit_done) begin
                    state_d = MC_WB;
                end else if (wd_hit) begin
                    err_d   = 1'b1;
                    state_d = MC_WB;
                end
            end
            MC_WB: begin
                if (wb_ready) begin
                    state_d = MC_IDLE;
                end
            end
            default: begin
                state_d = MC_IDLE;
            end
        endcase
    end

    // State, record and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MC_IDLE;
            rec_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rec_q   <= rec_d;
            err_q   <= err_d;
        end
    end

    // Output decode: record fields drive the unit/wb buses directly so they stay
    // stable from capture until the next accept.
    assign unit_start  = (state_q == MC_ISSUE);
    assign unit_op     = rec_q.op;
    assign wb_valid    = (state_q == MC_WB);
    assign wb_rd       = rec_q.rd;
    assign wb_fp       = rec_q.fp;
    assign wb_special  = rec_q.special;
    assign mc_busy     = (state_q != MC_IDLE);
    assign stall_ex    = (state_q != MC_IDLE) || accept;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_multicycle_unit_ctrl.sv
// Directed bench for multicycle_unit_ctrl.
// Latency: checks wb/stall timing against hand-computed cycle counts.
// Backpressure: exercises wb_ready held low in WB.
module tb_multicycle_unit_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ex_req;
    logic [1:0] ex_op;
    logic [4:0] ex_rd;
    logic       ex_div_zero;
    logic       ex_kill;
    logic       unit_start;
    logic [1:0] unit_op;
    logic       unit_done;
    logic       wb_valid;
    logic       wb_ready;
    logic [4:0] wb_rd;
    logic       wb_fp;
    logic       wb_special;
    logic       stall_ex;
    logic       mc_busy;
    logic       err_timeout;

    int checks;
    int errors;
    int stall_cnt;
    int start_cnt;
    int busy_cnt;
    int wbv_cyc;
    int hold_ok;

    multicycle_unit_ctrl #(
        .TIMEOUT (64),
        .CNT_W   (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_req      (ex_req),
        .ex_op       (ex_op),
        .ex_rd       (ex_rd),
        .ex_div_zero (ex_div_zero),
        .ex_kill     (ex_kill),
        .unit_start  (unit_start),
        .unit_op     (unit_op),
        .unit_done   (unit_done),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_fp       (wb_fp),
        .wb_special  (wb_special),
        .stall_ex    (stall_ex),
        .mc_busy     (mc_busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(unit_start), 32'd0);
        chk({tag, "_uop"},   32'(unit_op),    32'd0);
        chk({tag, "_wbv"},   32'(wb_valid),   32'd0);
        chk({tag, "_wbrd"},  32'(wb_rd),      32'd0);
        chk({tag, "_wbfp"},  32'(wb_fp),      32'd0);
        chk({tag, "_wbsp"},  32'(wb_special), 32'd0);
        chk({tag, "_stall"}, 32'(stall_ex),   32'd0);
        chk({tag, "_busy"},  32'(mc_busy),    32'd0);
        chk({tag, "_err"},   32'(err_timeout), 32'd0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
        ex_req      = 1'b0;
        ex_op       = 2'b00;
        ex_rd       = 5'd0;
        ex_div_zero = 1'b0;
        ex_kill     = 1'b0;
        unit_done   = 1'b0;
        wb_ready    = 1'b0;

        // Reset state
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // FDIV rd=7, unit_done 20 cycles after start, wb_ready already high
        ex_req = 1'b1; ex_op = 2'b10; ex_rd = 5'd7; wb_ready = 1'b1;
        stall_cnt = 0; start_cnt = 0; wbv_cyc = -1;
        #1;
        if (stall_ex) stall_cnt++;
        if (unit_start) start_cnt++;
        for (int c = 1; c <= 26; c++) begin
            tick();
            ex_req    = 1'b0;
            unit_done = (c == 21);
            #1;
            if (stall_ex) stall_cnt++;
            if (unit_start) start_cnt++;
            if (c == 1) chk("fdiv_unit_op", 32'(unit_op), 32'd2);
            if (wb_valid && wbv_cyc < 0) begin
                wbv_cyc = c;
                chk("fdiv_wb_rd", 32'(wb_rd), 32'd7);
                chk("fdiv_wb_fp", 32'(wb_fp), 32'd1);
                chk("fdiv_wb_sp", 32'(wb_special), 32'd0);
            end
        end
        unit_done = 1'b0;
        chk("fdiv_start_cnt", 32'(start_cnt), 32'd1);
        chk("fdiv_wbv_cycle", 32'(wbv_cyc), 32'd22);
        chk("fdiv_stall_cnt", 32'(stall_cnt), 32'd23);
        chk("fdiv_idle", 32'(mc_busy), 32'd0);

        // DIV by zero rd=3: no unit start, wb_valid 1 cycle after accept
        ex_req = 1'b1; ex_op = 2'b00; ex_rd = 5'd3; ex_div_zero = 1'b1;
        start_cnt = 0; wbv_cyc = -1;
        #1;
        chk("dz_accept_stall", 32'(stall_ex), 32'd1);
        if (unit_start) start_cnt++;
        for (int c = 1; c <= 4; c++) begin
            tick();
            ex_req = 1'b0; ex_div_zero = 1'b0;
            #1;
            if (unit_start) start_cnt++;
            if (wb_valid && wbv_cyc < 0) begin
                wbv_cyc = c;
                chk("dz_wb_sp", 32'(wb_special), 32'd1);
                chk("dz_wb_fp", 32'(wb_fp), 32'd0);
                chk("dz_wb_rd", 32'(wb_rd), 32'd3);
            end
        end
        chk("dz_start_cnt", 32'(start_cnt), 32'd0);
        chk("dz_wbv_cycle", 32'(wbv_cyc), 32'd1);

        // ex_req with ex_kill in IDLE: dropped
        ex_req = 1'b1; ex_kill = 1'b1; ex_op = 2'b01; ex_rd = 5'd11;
        stall_cnt = 0; start_cnt = 0; busy_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (stall_ex) stall_cnt++;
            if (unit_start) start_cnt++;
            if (mc_busy) busy_cnt++;
            tick();
        end
        ex_req = 1'b0; ex_kill = 1'b0;
        chk("kill_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("kill_start_cnt", 32'(start_cnt), 32'd0);
        chk("kill_busy_cnt", 32'(busy_cnt), 32'd0);

        // Spurious unit_done in IDLE is ignored
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        #1;
        chk("spur_busy", 32'(mc_busy), 32'd0);
        chk("spur_err", 32'(err_timeout), 32'd0);
        chk("spur_wbv", 32'(wb_valid), 32'd0);

        // REM rd=9 with wb_ready low for 5 cycles in WB
        ex_req = 1'b1; ex_op = 2'b01; ex_rd = 5'd9; wb_ready = 1'b0;
        tick();
        ex_req = 1'b0;
        tick();
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        hold_ok = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (wb_valid && (wb_rd == 5'd9) && stall_ex && !wb_fp) hold_ok++;
            tick();
        end
        chk("hold_stable_cycles", 32'(hold_ok), 32'd5);
        wb_ready = 1'b1;
        #1;
        chk("hold_hs_wbv", 32'(wb_valid), 32'd1);
        chk("hold_hs_stall", 32'(stall_ex), 32'd1);
        tick();
        wb_ready = 1'b0;
        #1;
        chk("hold_idle_busy", 32'(mc_busy), 32'd0);
        chk("hold_idle_wbv", 32'(wb_valid), 32'd0);
        chk("hold_idle_stall", 32'(stall_ex), 32'd0);

        // Timeout: DIV rd=5, unit_done never comes
        ex_req = 1'b1; ex_op = 2'b00; ex_rd = 5'd5;
        tick();
        ex_req = 1'b0;
        chk("to_issue_start", 32'(unit_start), 32'd1);
        repeat (64) tick();
        #1;
        chk("to_pre_err", 32'(err_timeout), 32'd0);
        chk("to_pre_wbv", 32'(wb_valid), 32'd0);
        chk("to_pre_busy", 32'(mc_busy), 32'd1);
        tick();
        #1;
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_wbv", 32'(wb_valid), 32'd1);
        chk("to_wb_rd", 32'(wb_rd), 32'd5);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        #1;
        chk("to_sticky_err", 32'(err_timeout), 32'd1);
        chk("to_idle_busy", 32'(mc_busy), 32'd0);

        // Async reset during WAIT, then FSQRT rd=12 (div_zero ignored for FP)
        ex_req = 1'b1; ex_op = 2'b00; ex_rd = 5'd4;
        tick();
        ex_req = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        ex_req = 1'b1; ex_op = 2'b11; ex_rd = 5'd12; ex_div_zero = 1'b1;
        #1;
        chk("sq_accept_stall", 32'(stall_ex), 32'd1);
        tick();
        ex_req = 1'b0; ex_div_zero = 1'b0;
        #1;
        chk("sq_start", 32'(unit_start), 32'd1);
        chk("sq_unit_op", 32'(unit_op), 32'd3);
        tick();
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        #1;
        chk("sq_wbv", 32'(wb_valid), 32'd1);
        chk("sq_wb_rd", 32'(wb_rd), 32'd12);
        chk("sq_wb_fp", 32'(wb_fp), 32'd1);
        chk("sq_wb_sp", 32'(wb_special), 32'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        #1;
        chk("sq_idle_busy", 32'(mc_busy), 32'd0);
        chk("sq_err", 32'(err_timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
